mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit; sits directly downstream of the execute-stage ALU and consumes its address result (base+offset) and the 8-bit op code for LB/LBU/LH/LHU/LW/SB/SH/SW.
- Performs alignment checks and drives an SRAM-like data bus (req / addr_ok / data_ok).
- Stalls the pipeline while a transaction is in flight, then returns sign- or zero-extended load data.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data width; only 32 supported

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- valid_i  in  1  M-stage instruction valid
- op_i  in  8  shared EXE_*_OP code
- addr_i  in  32  effective address from ALU result
- wdata_i  in  32  store source register (rt)
- flush_i  in  1  exception/flush; cancel current op
- stall_o  out  1  hold pipeline
- done_o  out  1  one-cycle pulse; load/store complete
- rdata_o  out  32  extended load result, valid while done_o=1
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- badvaddr_o  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address (unmasked)
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data

Behaviour:
- Reset values: state IDLE; every registered output 0, including data_req, done_o and rdata_o.
- mem op = any of the 8 load/store codes. A non-mem op or valid_i=0 passes through: no stall, no bus activity.
- accept = IDLE & valid_i & mem op & aligned & !flush_i.
- Alignment: halfword ops need addr_i[0]=0; word ops need addr_i[1:0]=0. Byte ops are always aligned.
- Misaligned op (in IDLE, valid, no flush):
  - No request is issued and stall_o stays 0.
  - In the same cycle (combinational): adel_o=1 for a load, ades_o=1 for a store, badvaddr_o=addr_i.
- State machine (IDLE, REQ, WAIT, DONE):
  - IDLE -> REQ on accept. On that edge, register wr, size, addr, wdata and load type.
  - REQ: data_req=1 with fields held stable.
    - Stay in REQ until data_addr_ok.
    - data_addr_ok alone -> WAIT.
    - data_addr_ok & data_data_ok in the same cycle -> DONE.
  - WAIT: data_req=0. On data_data_ok, register the extended read data into rdata_o and go to DONE.
  - DONE: done_o=1 and stall_o=0 for exactly one cycle, so the pipeline advances. No accept in this cycle. Next state IDLE.
- stall_o = accept | (state==REQ) | (state==WAIT), forced to 0 while the cancel flag is set.
- Store data lanes:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata unchanged
- Load extension: select byte/half lane by the registered addr[1:0] (little-endian). LB/LH sign-extend; LBU/LHU zero-extend; LW passes data unchanged.
- Flush:
  - In IDLE: blocks accept.
  - In REQ: data_req stays high until data_addr_ok (a request cannot be withdrawn) and the cancel flag is set.
  - In WAIT: the cancel flag is set.
  - When a cancelled transaction completes: rdata is discarded, done_o stays 0, next state IDLE, cancel cleared.
- Reset during any state: immediate return to IDLE with data_req=0. Any outstanding bus response is ignored.

Decomposition:
- Shared package/defines:
  - existing EXE_*_OP codes
  - SIZE_BYTE/HALF/WORD encodings
  - 2-bit state encodings
  - load-type enum (signed/unsigned, byte/half/word)
- Sub-module load_extend: combinational; inputs rdata, addr[1:0], load type; output extended 32-bit value. Reused by the verification model.

Test Plan:
- LW addr 0x00001000, addr_ok 2 cycles after req, data_ok 3 cycles later, rdata 0xDEADBEEF -> stall_o high throughout, done_o pulse, rdata_o=0xDEADBEEF, data_size=2.
- LB addr 0x00001003, rdata 0x80123456 -> rdata_o=0xFFFFFF80. Same access as LBU -> rdata_o=0x00000080.
- SH addr 0x00001002, wdata_i 0x1234ABCD -> data_wr=1, data_size=1, data_wdata=0xABCDABCD, done_o on data_ok.
- LW addr 0x00001001 -> adel_o=1, badvaddr_o=0x00001001, data_req never asserted, stall_o=0. SW addr 0x00001002 -> ades_o=1.
- REQ with addr_ok and data_ok in the same cycle -> DONE next cycle, no WAIT visit. flush_i during WAIT -> stall_o drops, done_o stays 0 when data_ok arrives.
- rst asserted mid-REQ -> data_req=0 and all outputs 0 immediately. A subsequent LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the memory-stage load/store unit: execute-stage op
//   codes, bus size encodings, FSM state encoding, load-type enum and small
//   decode helpers used by the unit.
package mem_access_unit_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        LT_B  = 3'd0,
        LT_BU = 3'd1,
        LT_H  = 3'd2,
        LT_HU = 3'd3,
        LT_W  = 3'd4
    } load_t;

    typedef struct packed {
        logic       is_mem;
        logic       is_store;
        logic [1:0] size;
        load_t      ltype;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t info;
        info.is_mem   = 1'b0;
        info.is_store = 1'b0;
        info.size     = SIZE_WORD;
        info.ltype    = LT_W;
        case (op)
            EXE_LB_OP:  begin info.is_mem = 1'b1; info.size = SIZE_BYTE; info.ltype = LT_B;  end
            EXE_LBU_OP: begin info.is_mem = 1'b1; info.size = SIZE_BYTE; info.ltype = LT_BU; end
            EXE_LH_OP:  begin info.is_mem = 1'b1; info.size = SIZE_HALF; info.ltype = LT_H;  end
            EXE_LHU_OP: begin info.is_mem = 1'b1; info.size = SIZE_HALF; info.ltype = LT_HU; end
            EXE_LW_OP:  begin info.is_mem = 1'b1; info.size = SIZE_WORD; info.ltype = LT_W;  end
            EXE_SB_OP:  begin info.is_mem = 1'b1; info.is_store = 1'b1; info.size = SIZE_BYTE; end
            EXE_SH_OP:  begin info.is_mem = 1'b1; info.is_store = 1'b1; info.size = SIZE_HALF; end
            EXE_SW_OP:  begin info.is_mem = 1'b1; info.is_store = 1'b1; info.size = SIZE_WORD; end
            default: ;
        endcase
        return info;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return ~addr_lo[0];
            SIZE_WORD: return (addr_lo == 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

    // The bus has no byte enables; the slave picks the lane from addr/size,
    // so narrow stores are replicated across every lane.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   SRAM-like data bus between the load/store unit (master) and memory (slave).
//   data_req/data_wr/data_size/data_addr/data_wdata : request from master
//   data_addr_ok : request accepted, data_data_ok : read data valid / write done
//   data_rdata   : read data
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// mem_access_unit_load_extend
//   Combinational load formatter: picks the byte/half lane addressed by
//   i_addr_lo (little-endian) and sign- or zero-extends it per i_ltype.
//   i_rdata : raw bus word, i_addr_lo : address bits [1:0],
//   i_ltype : load type, o_data : extended result
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  load_t       i_ltype,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ltype)
            LT_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LT_BU:   o_data = {24'h0, w_byte};
            LT_H:    o_data = {{16{w_half[15]}}, w_half};
            LT_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit. Checks alignment, runs one transaction at a
//   time on the SRAM-like bus, stalls the pipeline meanwhile and returns the
//   extended load result with a one-cycle done pulse.
//   clk, rst          : clock, async active-high reset
//   valid_i, op_i     : M-stage instruction valid and EXE_*_OP code
//   addr_i, wdata_i   : effective address, store source data
//   flush_i           : cancel current op
//   stall_o, done_o   : pipeline hold, completion pulse
//   rdata_o           : extended load data (valid with done_o)
//   adel_o, ades_o    : load/store address error, badvaddr_o : faulting addr
//   bus               : data bus master port
//
//   state  | meaning
//   IDLE   | no transaction; accept or raise address error
//   REQ    | data_req high, waiting for data_addr_ok
//   WAIT   | request accepted, waiting for data_data_ok
//   DONE   | one-cycle completion, pipeline released
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    mem_access_unit_if.master bus
);
    state_t            r_state;
    state_t            w_next;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    load_t             r_ltype;
    logic              r_cancel;
    logic [DATA_W-1:0] r_rdata;

    op_info_t          w_info;
    logic              w_aligned;
    logic              w_try;
    logic              w_accept;
    logic              w_misalign;
    logic              w_busy;
    logic              w_cancel;
    logic              w_resp;
    logic [31:0]       w_ext;

    assign w_info     = decode_op(op_i);
    assign w_aligned  = is_aligned(w_info.size, addr_i[1:0]);
    assign w_try      = (r_state == ST_IDLE) && valid_i && w_info.is_mem && !flush_i;
    assign w_accept   = w_try && w_aligned;
    assign w_misalign = w_try && !w_aligned;
    assign w_busy     = (r_state == ST_REQ) || (r_state == ST_WAIT);
    // A flush arriving in the same cycle as the response still cancels it.
    assign w_cancel   = r_cancel || (flush_i && w_busy);
    assign w_resp     = bus.data_data_ok &&
                        (((r_state == ST_REQ) && bus.data_addr_ok) || (r_state == ST_WAIT));

    assign adel_o     = w_misalign && !w_info.is_store;
    assign ades_o     = w_misalign && w_info.is_store;
    assign badvaddr_o = w_misalign ? addr_i : '0;
    assign rdata_o    = r_rdata;

    assign bus.data_req   = (r_state == ST_REQ);
    assign bus.data_wr    = r_wr;
    assign bus.data_size  = r_size;
    assign bus.data_addr  = r_addr;
    assign bus.data_wdata = r_wdata;

    mem_access_unit_load_extend u_load_extend (
        .i_rdata   (bus.data_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_ltype   (r_ltype),
        .o_data    (w_ext)
    );

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall_o = w_accept;
                if (w_accept) w_next = ST_REQ;
            end
            ST_REQ: begin
                stall_o = !w_cancel;
                if (bus.data_addr_ok) begin
                    if (!bus.data_data_ok) w_next = ST_WAIT;
                    else if (w_cancel)     w_next = ST_IDLE;
                    else                   w_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                stall_o = !w_cancel;
                if (bus.data_data_ok) w_next = w_cancel ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wr     <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ltype  <= LT_B;
            r_cancel <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_wr    <= w_info.is_store;
                r_size  <= w_info.size;
                r_addr  <= addr_i;
                r_wdata <= store_lanes(w_info.size, wdata_i);
                r_ltype <= w_info.ltype;
            end
            if (w_next == ST_IDLE)        r_cancel <= 1'b0;
            else if (flush_i && w_busy)   r_cancel <= 1'b1;
            if (w_resp && !r_wr && !w_cancel) r_rdata <= w_ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .op_i       (op_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .adel_o     (adel_o),
        .ades_o     (ades_o),
        .badvaddr_o (badvaddr_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic [1:0]  kind;      // 0 done, 1 adel, 2 ades
        logic        chk_data;
        logic [31:0] data;
        logic [31:0] bva;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat_a = 0;
    int   lat_d = 0;
    int   rs_phase = 0;
    int   rs_cnt = 0;
    logic [31:0] rs_rdata = 32'h0;
    int   n_done_seen = 0;
    int   n_done_exp = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_mem(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                          EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic int m_bytes(input logic [7:0] op);
        if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) return 1;
        if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] m_size(input logic [7:0] op);
        case (m_bytes(op))
            1:       return SIZE_BYTE;
            2:       return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic bit m_aligned(input logic [7:0] op, input logic [31:0] addr);
        return (addr % m_bytes(op)) == 0;
    endfunction

    function automatic logic [31:0] m_lanes(input logic [7:0] op, input logic [31:0] w);
        case (m_bytes(op))
            1:       return (w & 32'hFF) * 32'h0101_0101;
            2:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        if (m_bytes(op) == 4) return rd;
        mask = (m_bytes(op) == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * (addr & 3))) & mask;
        if ((op == EXE_LB_OP || op == EXE_LH_OP) && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    // ---------------- bus slave ----------------
    initial begin
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        forever begin
            req_t r;
            @(posedge clk);
            #2;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = $urandom();
            if (rst) begin
                rs_phase = 0;
                continue;
            end
            if (rs_phase == 0 && bus.data_req) begin
                if (req_q.size() == 0) begin
                    check("spurious_req", {95'h0, bus.data_req}, 96'h0);
                    rs_rdata = 32'h0;
                end else begin
                    r = req_q.pop_front();
                    check("req_fields",
                          {29'h0, bus.data_wr, bus.data_size, bus.data_addr,
                           (r.wr ? bus.data_wdata : 32'h0)},
                          {29'h0, r.wr, r.size, r.addr, r.wdata});
                    rs_rdata = r.rdata;
                end
                rs_cnt   = lat_a;
                rs_phase = 1;
            end
            if (rs_phase == 1) begin
                if (rs_cnt == 0) begin
                    bus.data_addr_ok = 1'b1;
                    if (lat_d == 0) begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = rs_rdata;
                        rs_phase = 0;
                    end else begin
                        rs_cnt   = lat_d;
                        rs_phase = 2;
                    end
                end else begin
                    rs_cnt--;
                end
            end else if (rs_phase == 2) begin
                rs_cnt--;
                if (rs_cnt == 0) begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = rs_rdata;
                    rs_phase = 0;
                end
            end
        end
    end

    // ---------------- completion monitor ----------------
    always @(negedge clk) begin
        cmp_t        e;
        logic [1:0]  gk;
        if (!rst && (done_o || adel_o || ades_o)) begin
            if (done_o) n_done_seen++;
            if (cmp_q.size() == 0) begin
                check("unexpected_event", {93'h0, done_o, adel_o, ades_o}, 96'h0);
            end else begin
                e  = cmp_q.pop_front();
                gk = done_o ? 2'd0 : (adel_o ? 2'd1 : 2'd2);
                check("completion",
                      {30'h0, gk, (e.chk_data ? rdata_o : 32'h0),
                       (e.kind == 2'd0 ? 32'h0 : badvaddr_o)},
                      {30'h0, e.kind, e.data, e.bva});
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge. fl >= 0 raises flush_i in that cycle
    // (counted from the issue cycle).
    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int la, input int ld, input int fl);
        bit          mem;
        bit          st;
        bit          al;
        int          cyc;
        logic        s;
        logic        ev_done;
        logic        ev_err;
        logic [33:0] exp_rel;
        cmp_t        c;
        req_t        r;
        mem = m_is_mem(op);
        st  = m_is_store(op);
        al  = m_aligned(op, addr);
        cyc = 0;
        lat_a = la;
        lat_d = ld;
        if (mem && al) begin
            r.wr    = st;
            r.size  = m_size(op);
            r.addr  = addr;
            r.wdata = st ? m_lanes(op, wd) : 32'h0;
            r.rdata = rd;
            req_q.push_back(r);
            if (fl < 0) begin
                c.kind     = 2'd0;
                c.chk_data = !st;
                c.data     = st ? 32'h0 : m_load(op, addr, rd);
                c.bva      = 32'h0;
                cmp_q.push_back(c);
                n_done_exp++;
            end
        end else if (mem) begin
            c.kind     = st ? 2'd2 : 2'd1;
            c.chk_data = 1'b0;
            c.data     = 32'h0;
            c.bva      = addr;
            cmp_q.push_back(c);
        end
        valid_i = 1'b1;
        op_i    = op;
        addr_i  = addr;
        wdata_i = wd;
        forever begin
            flush_i = (cyc == fl);
            @(negedge clk);
            s       = stall_o;
            ev_done = done_o;
            ev_err  = adel_o | ades_o;
            @(posedge clk);
            #1;
            if (!s) break;
            cyc++;
            if (cyc > 100) begin
                check("stall_timeout", {95'h0, s}, 96'h0);
                break;
            end
        end
        flush_i = 1'b0;
        valid_i = 1'b0;
        if (!mem)           exp_rel = {32'd0, 1'b0, 1'b0};
        else if (!al)       exp_rel = {32'd0, 1'b0, 1'b1};
        else if (fl >= 0)   exp_rel = {32'(fl), 1'b0, 1'b0};
        else                exp_rel = {32'(la + 2 + ld), 1'b1, 1'b0};
        check("release", {62'h0, 32'(cyc), ev_done, ev_err}, {62'h0, exp_rel});
        if (fl >= 0) begin
            @(negedge clk);
            check("cancel_stall", {95'h0, stall_o}, 96'h0);
            for (int k = 0; k < 50; k++) begin
                if (rs_phase == 0 && !bus.data_req) break;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops[9];
        rst     = 1'b1;
        valid_i = 1'b0;
        op_i    = 8'h0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        flush_i = 1'b0;
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'h21};

        @(negedge clk);
        check("reset_outs", {24'h0, stall_o, done_o, rdata_o, adel_o, ades_o, badvaddr_o, 4'h0},
              96'h0);
        check("reset_req", {95'h0, bus.data_req}, 96'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(EXE_LW_OP,  32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 3, -1);
        do_op(EXE_LB_OP,  32'h0000_1003, 32'h0, 32'h8012_3456, 1, 1, -1);
        do_op(EXE_LBU_OP, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 1, -1);
        do_op(EXE_SH_OP,  32'h0000_1002, 32'h1234_ABCD, 32'h0, 1, 2, -1);
        do_op(EXE_LW_OP,  32'h0000_1001, 32'h0, 32'h0, 0, 0, -1);
        do_op(EXE_SW_OP,  32'h0000_1002, 32'h5555_AAAA, 32'h0, 0, 0, -1);
        do_op(EXE_LH_OP,  32'h0000_1002, 32'h0, 32'h8001_7FFF, 1, 0, -1);
        do_op(EXE_LW_OP,  32'h0000_1004, 32'h0, 32'h1234_5678, 1, 4, 4);
        check("cancel_discard", {64'h0, rdata_o}, {64'h0, 32'hFFFF_8001});

        valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h0000_1000; flush_i = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", {95'h0, stall_o}, 96'h0);
        @(posedge clk);
        #1;
        flush_i = 1'b0; valid_i = 1'b0; op_i = EXE_SW_OP; addr_i = 32'h0000_1001;
        @(negedge clk);
        check("invalid_quiet", {94'h0, stall_o, ades_o}, 96'h0);
        @(posedge clk);
        #1;

        lat_a = 6;
        lat_d = 0;
        req_q.push_back('{1'b0, SIZE_WORD, 32'h0000_2000, 32'h0, 32'h1111_1111});
        valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h0000_2000;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("rst_pre_req", {95'h0, bus.data_req}, {95'h0, 1'b1});
        #1;
        rst = 1'b1;
        #1;
        check("rst_req", {95'h0, bus.data_req}, 96'h0);
        check("rst_outs", {60'h0, stall_o, done_o, rdata_o, adel_o, ades_o}, 96'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_q.delete();
        do_op(EXE_LW_OP, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 1, -1);

        for (int i = 0; i < 80; i++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            int          la;
            int          ld;
            int          fl;
            op   = ops[$urandom_range(0, 8)];
            addr = 32'h0000_1000 | ($urandom() & 32'hFFC) | 32'($urandom_range(0, 3));
            la   = $urandom_range(0, 3);
            ld   = $urandom_range(0, 3);
            fl   = -1;
            if (m_is_mem(op) && m_aligned(op, addr) && $urandom_range(0, 9) == 0)
                fl = $urandom_range(1, la + 1);
            do_op(op, addr, $urandom(), $urandom(), la, ld, fl);
        end

        repeat (3) @(posedge clk);
        #1;
        check("done_count", {64'h0, 32'(n_done_seen)}, {64'h0, 32'(n_done_exp)});
        check("pending", {64'h0, 32'(cmp_q.size() + req_q.size())}, 96'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
